// File: rtl/vdcm_pkg.sv
// Shared mux-word definitions for the substream demux and its parsers.
package vdcm_pkg;
    localparam int unsigned MUX_WORD_W = 128;
    localparam int unsigned NUM_SSM    = 4;

    typedef logic [MUX_WORD_W-1:0] mux_word_t;
endpackage

// File: rtl/ssm_mux_word_demux_ram.sv
// Flop-based word store for the mux-word demux: one write port, NRD async read ports.
module mux_word_ram
    import vdcm_pkg::*;
#(
    parameter int unsigned DW    = MUX_WORD_W,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned NRD   = NUM_SSM
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr [NRD],
    output logic [DW-1:0] o_rdata [NRD]
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NRD; k++) begin
            o_rdata[k] = r_mem[i_raddr[k]];
        end
    end

endmodule

// File: rtl/ssm_mux_word_demux.sv
// Mux-word buffer feeding the four substream parsers; serves up to NSSM in-order
// reads per cycle from consecutive buffered words.
module ssm_mux_word_demux
    import vdcm_pkg::*;
#(
    parameter int unsigned DW        = MUX_WORD_W,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AW        = $clog2(DEPTH),
    parameter int unsigned NSSM      = NUM_SSM,
    parameter int unsigned READY_THR = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic [DW-1:0]   in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NSSM-1:0] rd_en_ssm,
    output logic [DW-1:0]   data_ssm [NSSM],
    output logic [AW:0]     fill_level,
    output logic            dec_ready,
    output logic            underflow_err
);

    localparam logic [AW:0] FULL_LVL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] READY_LVL = (AW+1)'(READY_THR);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_underflow;

    logic          w_in_ready;
    logic          w_wr;
    logic [AW:0]   w_req_acc;
    logic [AW:0]   w_slot [NSSM];
    logic [NSSM-1:0] w_avail;
    logic [NSSM-1:0] w_grant;
    logic [AW:0]   w_n;
    logic          w_miss;
    logic [AW-1:0] w_raddr [NSSM];
    logic [DW-1:0] w_rdata [NSSM];

    assign w_in_ready = (r_count < FULL_LVL);
    // Gating the store as well keeps flush/reset cycles from touching memory.
    assign w_wr       = in_valid & w_in_ready & rstn & ~flush;

    mux_word_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW),
        .NRD   (NSSM)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr),
        .i_waddr (r_wr_ptr),
        .i_wdata (in_data),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Slot k is the prefix popcount of requests below k; idle ports still see lookahead.
    always_comb begin
        w_req_acc = '0;
        w_n       = '0;
        w_avail   = '0;
        w_grant   = '0;
        for (int unsigned k = 0; k < NSSM; k++) begin
            w_slot[k]   = w_req_acc;
            w_raddr[k]  = r_rd_ptr + w_req_acc[AW-1:0];
            w_avail[k]  = (w_req_acc < r_count);
            w_grant[k]  = rd_en_ssm[k] & w_avail[k];
            data_ssm[k] = w_avail[k] ? w_rdata[k] : '0;
            w_n         = w_n + (AW+1)'(w_grant[k]);
            w_req_acc   = w_req_acc + (AW+1)'(rd_en_ssm[k]);
        end
        w_miss = |(rd_en_ssm & ~w_grant);
    end

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= r_rd_ptr + w_n[AW-1:0];
            r_count  <= r_count + (AW+1)'(w_wr) - w_n;
            if (w_miss) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign in_ready      = w_in_ready;
    assign fill_level    = r_count;
    assign dec_ready     = (r_count >= READY_LVL);
    assign underflow_err = r_underflow;

endmodule
